partition_cut_scorer: RTL and testbench

Scoring stage directly downstream of the forge configurator. It consumes the per-node partition labels the forge produces, together with the graph adjacency weights, and computes fitness statistics that the evolutionary loop uses to rank strategy DNA: cut weight, internal weight and the count of nodes with a non-zero label. Both the partition vector and the adjacency matrix are read through synchronous single-cycle-latency read ports, never as flat arrays.

---
 rtl/forge_pkg.sv | 19 +
 rtl/partition_cut_scorer_tri_pair_counter.sv | 41 ++++
 rtl/partition_cut_scorer.sv | 157 +++++++++++++++
 tb/tb_partition_cut_scorer.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/forge_pkg.sv
// Shared definitions for the forge configurator and its neighbouring stages.
// Holds the scorer FSM encoding, the return-phase tag and the common width defaults.
package forge_pkg;

  localparam int LABEL_W_DEFAULT = 8;
  localparam int ACC_W_DEFAULT   = 32;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_COUNT  = 3'd1;
  localparam logic [2:0] ST_SCAN   = 3'd2;
  localparam logic [2:0] ST_DRAIN  = 3'd3;
  localparam logic [2:0] ST_RESULT = 3'd4;

  typedef enum logic {
    PH_COUNT = 1'b0,
    PH_SCAN  = 1'b1
  } phase_t;

endpackage

// File: rtl/partition_cut_scorer_tri_pair_counter.sv
// Walks (i,j) over the strict upper triangle in row-major order; holds on the last pair.
// clear loads the first pair (0,1); reset parks the counter at (0,0).
module tri_pair_counter #(
  parameter  int NUM_NODES = 256,
  localparam int AW        = $clog2(NUM_NODES)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          advance,
  output logic [AW-1:0] i,
  output logic [AW-1:0] j,
  output logic          first,
  output logic          last
);

  logic row_end;

  assign row_end = j == AW'(NUM_NODES - 1);
  assign first   = (i == '0) && (j == AW'(1));
  assign last    = (i == AW'(NUM_NODES - 2)) && row_end;

  // Row wrap goes from (i,N-1) to (i+1,i+2); never reached on the final row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i <= '0;
      j <= '0;
    end else if (clear) begin
      i <= '0;
      j <= AW'(1);
    end else if (advance && !last) begin
      if (row_end) begin
        i <= i + AW'(1);
        j <= i + AW'(2);
      end else begin
        j <= j + AW'(1);
      end
    end
  end

endmodule

// File: rtl/partition_cut_scorer.sv
// Scores a partition: cut weight, internal weight and non-zero label count,
// reading labels and adjacency weights through single-cycle-latency read ports.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for start; accumulators hold the previous result
// ST_COUNT  | one label read per node, n = 0..N-1
// ST_SCAN   | one (i,j) pair per cycle over the upper triangle
// ST_DRAIN  | absorbs the return of the final pair
// ST_RESULT | res_valid high until res_ready
module partition_cut_scorer
  import forge_pkg::*;
#(
  parameter  int NUM_NODES = 256,
  parameter  int PRECISION = 16,
  parameter  int LABEL_W   = LABEL_W_DEFAULT,
  parameter  int ACC_W     = ACC_W_DEFAULT,
  localparam int AW        = $clog2(NUM_NODES)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 busy,
  output logic                 adj_rd_en,
  output logic [AW-1:0]        adj_row,
  output logic [AW-1:0]        adj_col,
  input  logic [PRECISION-1:0] adj_rd_data,
  output logic                 part_rd_en,
  output logic [AW-1:0]        part_addr_a,
  output logic [AW-1:0]        part_addr_b,
  input  logic [LABEL_W-1:0]   part_data_a,
  input  logic [LABEL_W-1:0]   part_data_b,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [ACC_W-1:0]     cut_weight,
  output logic [ACC_W-1:0]     internal_weight,
  output logic [AW:0]          part1_count,
  output logic                 saturated
);

  if (NUM_NODES < 2) begin : g_bad_nodes
    $error("partition_cut_scorer: NUM_NODES must be >= 2");
  end
  if (ACC_W < PRECISION) begin : g_bad_acc
    $error("partition_cut_scorer: ACC_W must be >= PRECISION");
  end

  logic [2:0]      state;
  logic [AW-1:0]   node_cnt;
  logic [AW-1:0]   pc_i;
  logic [AW-1:0]   pc_j;
  logic            pc_first;
  logic            pc_last;
  logic            node_last;
  logic            start_ok;
  logic            ret_valid;
  phase_t          ret_phase;
  logic            labels_differ;
  logic [ACC_W-1:0] w_ext;
  logic [ACC_W:0]  cut_sum;
  logic [ACC_W:0]  int_sum;

  assign start_ok  = (state == ST_IDLE) && start;
  assign node_last = node_cnt == AW'(NUM_NODES - 1);

  tri_pair_counter #(.NUM_NODES(NUM_NODES)) u_pairs (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   ((state == ST_COUNT) && node_last),
    .advance (state == ST_SCAN),
    .i       (pc_i),
    .j       (pc_j),
    .first   (pc_first),
    .last    (pc_last)
  );

  assign busy       = (state == ST_COUNT) || (state == ST_SCAN) || (state == ST_DRAIN);
  assign res_valid  = state == ST_RESULT;
  assign adj_rd_en  = state == ST_SCAN;
  assign part_rd_en = (state == ST_COUNT) || (state == ST_SCAN);

  // The pair counter only moves during SCAN, so outside it the addresses hold.
  assign adj_row     = pc_i;
  assign adj_col     = pc_j;
  assign part_addr_a = (state == ST_COUNT) ? node_cnt : pc_i;
  assign part_addr_b = pc_j;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      node_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_COUNT;
            node_cnt <= '0;
          end
        end
        ST_COUNT: begin
          if (node_last) state <= ST_SCAN;
          else           node_cnt <= node_cnt + AW'(1);
        end
        ST_SCAN:   if (pc_last) state <= ST_DRAIN;
        ST_DRAIN:  state <= ST_RESULT;
        ST_RESULT: if (res_ready) state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  assign w_ext         = ACC_W'(adj_rd_data);
  assign labels_differ = part_data_a != part_data_b;
  assign cut_sum       = {1'b0, cut_weight} + {1'b0, w_ext};
  assign int_sum       = {1'b0, internal_weight} + {1'b0, w_ext};

  // Returns are dispatched purely by tag; the first pair being scanned is the
  // cycle in which the last label-count return lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ret_valid       <= 1'b0;
      ret_phase       <= PH_COUNT;
      cut_weight      <= '0;
      internal_weight <= '0;
      part1_count     <= '0;
      saturated       <= 1'b0;
    end else begin
      ret_valid <= part_rd_en;
      ret_phase <= (adj_rd_en || pc_first && state == ST_SCAN) ? PH_SCAN : PH_COUNT;
      if (start_ok) begin
        cut_weight      <= '0;
        internal_weight <= '0;
        part1_count     <= '0;
        saturated       <= 1'b0;
      end else if (ret_valid) begin
        if (ret_phase == PH_COUNT) begin
          if (part_data_a != '0) part1_count <= part1_count + (AW+1)'(1);
        end else if (labels_differ) begin
          if (cut_sum[ACC_W]) begin
            cut_weight <= '1;
            saturated  <= 1'b1;
          end else begin
            cut_weight <= cut_sum[ACC_W-1:0];
          end
        end else begin
          if (int_sum[ACC_W]) begin
            internal_weight <= '1;
            saturated       <= 1'b1;
          end else begin
            internal_weight <= int_sum[ACC_W-1:0];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_partition_cut_scorer.sv
// Bench for partition_cut_scorer: three configurations (N=4/ACC 32, N=4/ACC 8, N=2)
// with behavioural label/weight memories and a pair-sum reference model.
module tb_partition_cut_scorer;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b0;

  int tests_run = 0;
  int tests_failed = 0;

  logic [15:0] w   [3][4][4];
  logic [7:0]  lab [3][4];

  // instance 0: N=4, PRECISION=16, ACC_W=32
  logic start0 = 0, rr0 = 0, busy0, aen0, pen0, rv0, sat0;
  logic [1:0] row0, col0, pa0, pb0;
  logic [15:0] adat0 = '0;
  logic [7:0] da0 = '0, db0 = '0;
  logic [31:0] cut0, int0;
  logic [2:0] cnt0;
  // instance 1: N=4, PRECISION=8, ACC_W=8
  logic start1 = 0, rr1 = 0, busy1, aen1, pen1, rv1, sat1;
  logic [1:0] row1, col1, pa1, pb1;
  logic [7:0] adat1 = '0;
  logic [7:0] da1 = '0, db1 = '0;
  logic [7:0] cut1, int1;
  logic [2:0] cnt1;
  // instance 2: N=2, PRECISION=16, ACC_W=32
  logic start2 = 0, rr2 = 0, busy2, aen2, pen2, rv2, sat2;
  logic [0:0] row2, col2, pa2, pb2;
  logic [15:0] adat2 = '0;
  logic [7:0] da2 = '0, db2 = '0;
  logic [31:0] cut2, int2;
  logic [1:0] cnt2;

  partition_cut_scorer #(.NUM_NODES(4), .PRECISION(16), .LABEL_W(8), .ACC_W(32)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .busy(busy0),
    .adj_rd_en(aen0), .adj_row(row0), .adj_col(col0), .adj_rd_data(adat0),
    .part_rd_en(pen0), .part_addr_a(pa0), .part_addr_b(pb0),
    .part_data_a(da0), .part_data_b(db0),
    .res_valid(rv0), .res_ready(rr0), .cut_weight(cut0), .internal_weight(int0),
    .part1_count(cnt0), .saturated(sat0));

  partition_cut_scorer #(.NUM_NODES(4), .PRECISION(8), .LABEL_W(8), .ACC_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1),
    .adj_rd_en(aen1), .adj_row(row1), .adj_col(col1), .adj_rd_data(adat1),
    .part_rd_en(pen1), .part_addr_a(pa1), .part_addr_b(pb1),
    .part_data_a(da1), .part_data_b(db1),
    .res_valid(rv1), .res_ready(rr1), .cut_weight(cut1), .internal_weight(int1),
    .part1_count(cnt1), .saturated(sat1));

  partition_cut_scorer #(.NUM_NODES(2), .PRECISION(16), .LABEL_W(8), .ACC_W(32)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .busy(busy2),
    .adj_rd_en(aen2), .adj_row(row2), .adj_col(col2), .adj_rd_data(adat2),
    .part_rd_en(pen2), .part_addr_a(pa2), .part_addr_b(pb2),
    .part_data_a(da2), .part_data_b(db2),
    .res_valid(rv2), .res_ready(rr2), .cut_weight(cut2), .internal_weight(int2),
    .part1_count(cnt2), .saturated(sat2));

  // Synchronous read memories: data valid the cycle after the strobe.
  always @(posedge clk) begin
    if (aen0) adat0 <= w[0][row0][col0];
    if (pen0) begin da0 <= lab[0][pa0]; db0 <= lab[0][pb0]; end
    if (aen1) adat1 <= w[1][row1][col1][7:0];
    if (pen1) begin da1 <= lab[1][pa1]; db1 <= lab[1][pb1]; end
    if (aen2) adat2 <= w[2][row2][col2];
    if (pen2) begin da2 <= lab[2][pa2]; db2 <= lab[2][pb2]; end
  end

  logic [7:0] alog[$];
  int nlog[$];
  always @(posedge clk) begin
    if (aen0)      alog.push_back({row0, col0, pa0, pb0});
    else if (pen0) nlog.push_back(int'(pa0));
  end

  task automatic clear_graph(input int k);
    for (int i = 0; i < 4; i++) begin
      lab[k][i] = 8'h00;
      for (int j = 0; j < 4; j++) w[k][i][j] = 16'h0000;
    end
  endtask

  task automatic set_w(input int k, input int i, input int j, input logic [15:0] v);
    w[k][i][j] = v;
    w[k][j][i] = v;
  endtask

  task automatic set_start(input int k, input logic v);
    case (k)
      0: start0 = v;
      1: start1 = v;
      default: start2 = v;
    endcase
  endtask

  task automatic set_ready(input int k, input logic v);
    case (k)
      0: rr0 = v;
      1: rr1 = v;
      default: rr2 = v;
    endcase
  endtask

  task automatic get_res(input int k, output logic [31:0] cut, output logic [31:0] iw,
                         output int cnt, output logic sat, output logic rv, output logic bz);
    case (k)
      0: begin cut = cut0; iw = int0; cnt = int'(cnt0); sat = sat0; rv = rv0; bz = busy0; end
      1: begin cut = {24'h0, cut1}; iw = {24'h0, int1}; cnt = int'(cnt1); sat = sat1; rv = rv1; bz = busy1; end
      default: begin cut = cut2; iw = int2; cnt = int'(cnt2); sat = sat2; rv = rv2; bz = busy2; end
    endcase
  endtask

  // Reference: direct sum over i<j, then clip; monotonic adds make clip-at-end equivalent.
  function automatic void model(input int k, output logic [31:0] cut, output logic [31:0] iw,
                                output int cnt, output logic sat);
    longint c = 0, it = 0, mx;
    int n = (k == 2) ? 2 : 4;
    mx = (k == 1) ? 64'd255 : 64'hFFFF_FFFF;
    cnt = 0;
    for (int i = 0; i < n; i++) if (lab[k][i] != 0) cnt++;
    for (int i = 0; i < n; i++)
      for (int j = i + 1; j < n; j++)
        if (lab[k][i] == lab[k][j]) it += longint'(w[k][i][j]);
        else                        c  += longint'(w[k][i][j]);
    sat = (c > mx) || (it > mx);
    cut = 32'((c > mx) ? mx : c);
    iw  = 32'((it > mx) ? mx : it);
  endfunction

  task automatic run_to_result(input int k, output int lat_cycle, output bit timed_out);
    logic [31:0] c, iw; int n; logic s, rv, bz;
    @(negedge clk); set_start(k, 1'b1);
    @(posedge clk); #1; set_start(k, 1'b0);
    timed_out = 1'b1;
    lat_cycle = 0;
    for (int e = 0; e < 100; e++) begin
      get_res(k, c, iw, n, s, rv, bz);
      if (rv) begin lat_cycle = e + 1; timed_out = 1'b0; break; end
      @(posedge clk); #1;
    end
  endtask

  task automatic accept(input int k);
    @(negedge clk); set_ready(k, 1'b1);
    @(posedge clk); #1; set_ready(k, 1'b0);
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) clear_graph(k);
    #12;
    tests_run++; if (busy0 !== 1'b0 || rv0 !== 1'b0) begin tests_failed++; $display("FAIL reset_handshake: busy=%b res_valid=%b expected 0 0", busy0, rv0); end
    tests_run++; if (aen0 !== 1'b0 || pen0 !== 1'b0) begin tests_failed++; $display("FAIL reset_strobes: adj=%b part=%b expected 0 0", aen0, pen0); end
    tests_run++; if ({row0, col0, pa0, pb0} !== 8'h00) begin tests_failed++; $display("FAIL reset_addr: got %h expected 00", {row0, col0, pa0, pb0}); end
    tests_run++; if (cut0 !== 32'd0 || int0 !== 32'd0) begin tests_failed++; $display("FAIL reset_weights: cut=%0d int=%0d expected 0 0", cut0, int0); end
    tests_run++; if (cnt0 !== 3'd0 || sat0 !== 1'b0) begin tests_failed++; $display("FAIL reset_count_sat: cnt=%0d sat=%b expected 0 0", cnt0, sat0); end
    tests_run++; if (rv2 !== 1'b0 || cut2 !== 32'd0 || rv1 !== 1'b0) begin tests_failed++; $display("FAIL reset_other: rv2=%b cut2=%0d rv1=%b expected 0", rv2, cut2, rv1); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [31:0] cut, iw; int cnt, lat; logic sat, rv, bz; bit to;
    clear_graph(0);
    lab[0][0] = 0; lab[0][1] = 0; lab[0][2] = 1; lab[0][3] = 1;
    set_w(0, 0, 1, 5); set_w(0, 0, 2, 3); set_w(0, 1, 3, 2); set_w(0, 2, 3, 7);
    run_to_result(0, lat, to);
    get_res(0, cut, iw, cnt, sat, rv, bz);
    tests_run++; if (to !== 1'b0 || lat !== 12) begin tests_failed++; $display("FAIL basic_latency: timeout=%b cycle=%0d expected cycle 12", to, lat); end
    tests_run++; if (cut !== 32'd5) begin tests_failed++; $display("FAIL basic_cut: got %0d expected 5", cut); end
    tests_run++; if (iw !== 32'd12) begin tests_failed++; $display("FAIL basic_internal: got %0d expected 12", iw); end
    tests_run++; if (cnt !== 2 || sat !== 1'b0) begin tests_failed++; $display("FAIL basic_count_sat: cnt=%0d sat=%b expected 2 0", cnt, sat); end
    tests_run++; if (bz !== 1'b0) begin tests_failed++; $display("FAIL basic_busy: got %b expected 0", bz); end
    accept(0);
  endtask

  task automatic test_uniform();
    logic [31:0] cut, iw; int cnt, lat; logic sat, rv, bz; bit to;
    logic [7:0] exp_q[$];
    logic [1:0] ii, jj;
    clear_graph(0);
    for (int i = 0; i < 4; i++) begin
      lab[0][i] = 1;
      for (int j = 0; j < 4; j++) if (i != j) w[0][i][j] = 1;
    end
    for (int i = 0; i < 4; i++)
      for (int j = i + 1; j < 4; j++) begin
        ii = 2'(i); jj = 2'(j);
        exp_q.push_back({ii, jj, ii, jj});
      end
    alog.delete(); nlog.delete();
    run_to_result(0, lat, to);
    get_res(0, cut, iw, cnt, sat, rv, bz);
    tests_run++; if (to !== 1'b0 || cut !== 32'd0 || iw !== 32'd6 || cnt !== 4) begin tests_failed++; $display("FAIL uniform_result: to=%b cut=%0d int=%0d cnt=%0d expected 0 0 6 4", to, cut, iw, cnt); end
    tests_run++; if (nlog.size() !== 4 || alog.size() !== 6) begin tests_failed++; $display("FAIL uniform_issue_count: count=%0d pairs=%0d expected 4 6", nlog.size(), alog.size()); end
    for (int n = 0; n < 4 && n < nlog.size(); n++) begin
      tests_run++; if (nlog[n] !== n) begin tests_failed++; $display("FAIL uniform_count_addr[%0d]: got %0d expected %0d", n, nlog[n], n); end
    end
    for (int p = 0; p < 6 && p < alog.size(); p++) begin
      tests_run++; if (alog[p] !== exp_q[p]) begin tests_failed++; $display("FAIL uniform_pair[%0d]: got %h expected %h", p, alog[p], exp_q[p]); end
    end
    accept(0);
  endtask

  task automatic test_saturate();
    logic [31:0] cut, iw; int cnt, lat; logic sat, rv, bz; bit to;
    clear_graph(1);
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) if (i != j) w[1][i][j] = 16'h00FF;
    run_to_result(1, lat, to);
    get_res(1, cut, iw, cnt, sat, rv, bz);
    tests_run++; if (to !== 1'b0 || iw !== 32'd255 || sat !== 1'b1) begin tests_failed++; $display("FAIL sat_clip: to=%b int=%0d sat=%b expected 255 1", to, iw, sat); end
    tests_run++; if (cut !== 32'd0 || cnt !== 0) begin tests_failed++; $display("FAIL sat_cut: cut=%0d cnt=%0d expected 0 0", cut, cnt); end
    accept(1);
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) if (i != j) w[1][i][j] = 16'h0001;
    run_to_result(1, lat, to);
    get_res(1, cut, iw, cnt, sat, rv, bz);
    tests_run++; if (to !== 1'b0 || iw !== 32'd6 || sat !== 1'b0) begin tests_failed++; $display("FAIL sat_cleared: to=%b int=%0d sat=%b expected 6 0", to, iw, sat); end
    accept(1);
  endtask

  task automatic test_hold();
    logic [31:0] cut, iw; int cnt, lat; logic sat, rv, bz; bit to;
    clear_graph(0);
    lab[0][0] = 0; lab[0][1] = 0; lab[0][2] = 1; lab[0][3] = 1;
    set_w(0, 0, 1, 5); set_w(0, 0, 2, 3); set_w(0, 1, 3, 2); set_w(0, 2, 3, 7);
    run_to_result(0, lat, to);
    tests_run++; if (to !== 1'b0) begin tests_failed++; $display("FAIL hold_timeout: no res_valid within bound"); end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); start0 = (c == 4);
      @(posedge clk); #1;
      get_res(0, cut, iw, cnt, sat, rv, bz);
      tests_run++;
      if (cut !== 32'd5 || iw !== 32'd12 || cnt !== 2 || sat !== 1'b0 || rv !== 1'b1 || bz !== 1'b0) begin
        tests_failed++;
        $display("FAIL hold_stable[%0d]: cut=%0d int=%0d cnt=%0d sat=%b rv=%b busy=%b expected 5 12 2 0 1 0", c, cut, iw, cnt, sat, rv, bz);
      end
    end
    start0 = 1'b0;
    accept(0);
    @(posedge clk); #1;
    tests_run++; if (rv0 !== 1'b0 || busy0 !== 1'b0) begin tests_failed++; $display("FAIL hold_accept: rv=%b busy=%b expected 0 0", rv0, busy0); end
    run_to_result(0, lat, to);
    get_res(0, cut, iw, cnt, sat, rv, bz);
    tests_run++; if (to !== 1'b0 || lat !== 12 || cut !== 32'd5 || iw !== 32'd12 || cnt !== 2) begin tests_failed++; $display("FAIL hold_rerun: lat=%0d cut=%0d int=%0d cnt=%0d expected 12 5 12 2", lat, cut, iw, cnt); end
    accept(0);
  endtask

  task automatic test_reset_mid();
    logic [31:0] cut, iw, ecut, eiw; int cnt, ecnt, lat; logic sat, esat, rv, bz; bit to, found;
    clear_graph(0);
    for (int i = 0; i < 4; i++) lab[0][i] = 8'(i % 3);
    for (int i = 0; i < 4; i++) for (int j = i + 1; j < 4; j++) set_w(0, i, j, 16'(10 * i + j + 1));
    @(negedge clk); start0 = 1'b1;
    @(posedge clk); #1; start0 = 1'b0;
    found = 1'b0;
    for (int e = 0; e < 40; e++) begin
      if (aen0 && row0 == 2'd1 && col0 == 2'd2) begin found = 1'b1; break; end
      @(posedge clk); #1;
    end
    tests_run++; if (found !== 1'b1) begin tests_failed++; $display("FAIL midreset_reach: pair (1,2) not issued within bound"); end
    rst_n = 1'b0;
    #1;
    tests_run++; if (cut0 !== 32'd0 || int0 !== 32'd0 || cnt0 !== 3'd0 || sat0 !== 1'b0) begin tests_failed++; $display("FAIL midreset_acc: cut=%0d int=%0d cnt=%0d sat=%b expected 0", cut0, int0, cnt0, sat0); end
    tests_run++; if (busy0 !== 1'b0 || rv0 !== 1'b0 || aen0 !== 1'b0 || pen0 !== 1'b0) begin tests_failed++; $display("FAIL midreset_ctrl: busy=%b rv=%b adj=%b part=%b expected 0", busy0, rv0, aen0, pen0); end
    @(negedge clk); rst_n = 1'b1;
    model(0, ecut, eiw, ecnt, esat);
    run_to_result(0, lat, to);
    get_res(0, cut, iw, cnt, sat, rv, bz);
    tests_run++; if (to !== 1'b0 || cut !== ecut || iw !== eiw || cnt !== ecnt || sat !== esat) begin tests_failed++; $display("FAIL midreset_rerun: cut=%0d int=%0d cnt=%0d sat=%b expected %0d %0d %0d %b", cut, iw, cnt, sat, ecut, eiw, ecnt, esat); end
    accept(0);
  endtask

  task automatic test_two_nodes();
    logic [31:0] cut, iw; int cnt, lat; logic sat, rv, bz; bit to;
    clear_graph(2);
    lab[2][0] = 3; lab[2][1] = 5;
    set_w(2, 0, 1, 9);
    run_to_result(2, lat, to);
    get_res(2, cut, iw, cnt, sat, rv, bz);
    tests_run++; if (to !== 1'b0 || lat !== 5) begin tests_failed++; $display("FAIL two_latency: to=%b cycle=%0d expected 5", to, lat); end
    tests_run++; if (cut !== 32'd9 || iw !== 32'd0 || cnt !== 2 || sat !== 1'b0) begin tests_failed++; $display("FAIL two_result: cut=%0d int=%0d cnt=%0d sat=%b expected 9 0 2 0", cut, iw, cnt, sat); end
    accept(2);
  endtask

  task automatic test_random();
    logic [31:0] cut, iw, ecut, eiw; int cnt, ecnt, lat; logic sat, esat, rv, bz; bit to;
    for (int r = 0; r < 16; r++) begin
      int k = r % 2;
      clear_graph(k);
      for (int i = 0; i < 4; i++) lab[k][i] = 8'($urandom_range(0, 2));
      for (int i = 0; i < 4; i++)
        for (int j = i + 1; j < 4; j++)
          set_w(k, i, j, (k == 0) ? 16'($urandom_range(0, 65535)) : 16'($urandom_range(0, 255)));
      model(k, ecut, eiw, ecnt, esat);
      run_to_result(k, lat, to);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      get_res(k, cut, iw, cnt, sat, rv, bz);
      tests_run++;
      if (to !== 1'b0 || lat !== 12 || cut !== ecut || iw !== eiw || cnt !== ecnt || sat !== esat || rv !== 1'b1) begin
        tests_failed++;
        $display("FAIL random[%0d] inst%0d: lat=%0d cut=%0d int=%0d cnt=%0d sat=%b expected 12 %0d %0d %0d %b",
                 r, k, lat, cut, iw, cnt, sat, ecut, eiw, ecnt, esat);
      end
      accept(k);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_uniform();
    test_saturate();
    test_hold();
    test_reset_mid();
    test_two_nodes();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
